// File: rtl/capture_ctrl.sv
// capture_ctrl: takes the SPI-written control word into the ADC clock domain and runs one
// arm/trigger/capture sequence into the sample buffer RAM.
//
// Ports:
//   clk         ADC sample clock, the only clock of the block
//   rst_n       asynchronous active-low reset
//   cntrl_bits  control word, async to clk: [0] arm, [1] trig_mode, [2] continuous,
//               [3] reserved, [6:4] depth_code, [7] abort
//   ext_trig    asynchronous external trigger, rising-edge active
//   data_in     ADC sample, valid every clk
//   wr_en       buffer write strobe
//   wr_addr     buffer write address
//   wr_data     buffer write data (data_in delayed one clk)
//   busy        high while armed or capturing
//   done        high once a single-shot capture has filled the buffer
//   wrapped     sticky: continuous capture has wrapped at least once
module capture_ctrl #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        cntrl_bits,
  input  logic              ext_trig,
  input  logic [DATA_W-1:0] data_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              wrapped
);

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

  localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Last buffer address for a depth code: 2^(code+7) - 1, clamped to the full address space.
  function automatic logic [ADDR_W-1:0] depth_last(input logic [2:0] code);
    int unsigned sh;
    sh = 32'(code) + 32'd7;
    if (sh >= ADDR_W) begin
      return '1;
    end
    return (AddrOne << sh) - AddrOne;
  endfunction

  logic [7:0]        ctrl_s1_q, ctrl_s2_q, ctrl_s3_q, ctrl_filt_q;
  logic              arm_prev_q;
  logic              trig_s1_q, trig_s2_q, trig_s3_q, trig_edge_q;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              wrapped_q, wrapped_d;
  logic [DATA_W-1:0] wr_data_q;

  logic       f_arm, f_trig_mode, f_cont, f_abort, arm_edge;
  logic [2:0] f_depth;
  logic       unused_rsvd;

  assign f_arm       = ctrl_filt_q[0];
  assign f_trig_mode = ctrl_filt_q[1];
  assign f_cont      = ctrl_filt_q[2];
  assign f_depth     = ctrl_filt_q[6:4];
  assign f_abort     = ctrl_filt_q[7];
  assign unused_rsvd = ctrl_filt_q[3];
  assign arm_edge    = f_arm & ~arm_prev_q;

  // Two-flop synchronisers plus a stability filter: the decoded word only moves once the
  // synchronised word has been identical on two consecutive clocks, so a multi-bit SPI
  // update that lands skewed across the synchronisers never decodes as a bogus word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_s1_q   <= '0;
      ctrl_s2_q   <= '0;
      ctrl_s3_q   <= '0;
      ctrl_filt_q <= '0;
      arm_prev_q  <= 1'b0;
      trig_s1_q   <= 1'b0;
      trig_s2_q   <= 1'b0;
      trig_s3_q   <= 1'b0;
      trig_edge_q <= 1'b0;
    end else begin
      ctrl_s1_q <= cntrl_bits;
      ctrl_s2_q <= ctrl_s1_q;
      ctrl_s3_q <= ctrl_s2_q;
      if (ctrl_s2_q == ctrl_s3_q) begin
        ctrl_filt_q <= ctrl_s2_q;
      end
      arm_prev_q  <= ctrl_filt_q[0];
      trig_s1_q   <= ext_trig;
      trig_s2_q   <= trig_s1_q;
      trig_s3_q   <= trig_s2_q;
      trig_edge_q <= trig_s2_q & ~trig_s3_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    last_d    = last_q;
    wrapped_d = wrapped_q;
    unique case (state_q)
      StIdle: begin
        // Abort in the same word swallows the arm edge; arm must drop and rise again.
        if (arm_edge && !f_abort) begin
          addr_d    = '0;
          wrapped_d = 1'b0;
          last_d    = depth_last(f_depth);
          state_d   = f_trig_mode ? StArmed : StCapture;
        end
      end
      StArmed: begin
        if (!f_arm || f_abort) begin
          state_d = StIdle;
        end else if (trig_edge_q) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (!f_arm || f_abort) begin
          state_d = StIdle;
        end else if (addr_q == last_q) begin
          // continuous is read live so clearing it ends the run at the next buffer end
          if (f_cont) begin
            addr_d    = '0;
            wrapped_d = 1'b1;
          end else begin
            state_d = StDone;
          end
        end else begin
          addr_d = addr_q + AddrOne;
        end
      end
      StDone: begin
        if (!f_arm) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      last_q    <= '0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      last_q    <= last_d;
      wrapped_q <= wrapped_d;
    end
  end

  // Register the sample on the edge that enters/continues CAPTURE so it lines up with
  // wr_en/wr_addr of the same cycle; held at zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_data_q <= '0;
    end else if (state_d == StCapture) begin
      wr_data_q <= data_in;
    end else begin
      wr_data_q <= '0;
    end
  end

  // Status decoded straight from the state register so reset clears it asynchronously.
  always_comb begin
    wr_en   = (state_q == StCapture);
    busy    = (state_q == StArmed) || (state_q == StCapture);
    done    = (state_q == StDone);
    wr_addr = addr_q;
    wr_data = wr_data_q;
    wrapped = wrapped_q;
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed self-checking bench for capture_ctrl. Inputs change on/after negedges or just
// after posedges; outputs are checked on negedges.
module tb_capture_ctrl;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 12;

  logic          clk;
  logic          rst_n;
  logic [7:0]    cntrl_bits;
  logic          ext_trig;
  logic [DW-1:0] data_in;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          wrapped;

  logic [DW-1:0] din_sampled;  // data_in as seen at the most recent posedge
  int n_checks = 0;
  int n_fail   = 0;

  capture_ctrl #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cntrl_bits(cntrl_bits),
    .ext_trig  (ext_trig),
    .data_in   (data_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .wrapped   (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fresh sample every clk, changed 1 time unit after the edge that registers the old one.
  initial begin
    data_in     = '0;
    din_sampled = '0;
    forever begin
      @(posedge clk);
      din_sampled = data_in;
      #1 data_in = DW'($urandom);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for wr_en to rise; cnt is the clk edge index after the stimulus edge.
  task automatic wait_wr(input string tag, input int lo, input int hi);
    int cnt = 0;
    @(negedge clk);
    while (!wr_en && cnt < 30) begin
      cnt++;
      @(negedge clk);
    end
    check_eq($sformatf("%s_start_latency_%0d_allowed_%0d_to_%0d", tag, cnt, lo, hi),
             32'(cnt >= lo && cnt <= hi), 32'd1);
  endtask

  task automatic wait_low(input string tag, input int hi);
    int cnt = 0;
    @(negedge clk);
    while (wr_en && cnt < 30) begin
      cnt++;
      @(negedge clk);
    end
    check_eq($sformatf("%s_stop_latency_%0d_max_%0d", tag, cnt, hi), 32'(cnt <= hi), 32'd1);
  endtask

  task automatic count_wr(input int n, output int c);
    c = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (wr_en) c++;
    end
  endtask

  // Checks n consecutive write cycles starting at write index first; called on a negedge
  // where a write is expected, returns on the negedge after the last checked write.
  task automatic check_writes(input string tag, input int first, input int n, input int depth,
                              input bit cont, input bit poke_trig);
    logic exp_wrap;
    for (int i = first; i < first + n; i++) begin
      exp_wrap = cont && (i >= depth);
      check_eq($sformatf("%s_ctl[%0d]", tag, i), 32'({wr_en, busy, done, wrapped, wr_addr}),
               32'({1'b1, 1'b1, 1'b0, exp_wrap, AW'(i % depth)}));
      check_eq($sformatf("%s_data[%0d]", tag, i), 32'(wr_data), 32'(din_sampled));
      if (poke_trig) begin
        if (i == 10) ext_trig = 1'b0;
        if (i == 30) ext_trig = 1'b1;
        if (i == 40) ext_trig = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int c, c2;
    rst_n      = 1'b0;
    cntrl_bits = 8'h00;
    ext_trig   = 1'b0;

    // Reset: inputs wiggle, outputs must stay zero.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq($sformatf("rst_outs[%0d]", k),
               32'({wr_en, busy, done, wrapped, wr_addr, wr_data}), 32'd0);
      cntrl_bits = 8'($urandom);
      ext_trig   = ~ext_trig;
    end
    @(negedge clk);
    cntrl_bits = 8'h00;
    ext_trig   = 1'b0;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_eq($sformatf("idle_outs[%0d]", k),
               32'({wr_en, busy, done, wrapped, wr_addr, wr_data}), 32'd0);
    end

    // Immediate single-shot capture, depth 128.
    cntrl_bits = 8'h01;
    wait_wr("imm", 4, 5);
    check_writes("imm", 0, 128, 128, 1'b0, 1'b0);
    check_eq("imm_done_state", 32'({wr_en, busy, done, wr_addr}), 32'({3'b001, AW'(127)}));
    count_wr(20, c);
    check_eq("imm_no_retrigger", 32'(c), 32'd0);
    check_eq("imm_done_held", 32'(done), 32'd1);
    cntrl_bits = 8'h00;
    count_wr(8, c);
    check_eq("imm_release", 32'({done, busy, wrapped, wr_addr}), 32'({3'b000, AW'(127)}));

    // External trigger, depth 256.
    cntrl_bits = 8'h13;
    count_wr(12, c);
    check_eq("trig_armed_no_wr", 32'(c), 32'd0);
    check_eq("trig_armed_state", 32'({busy, done, wr_en}), 32'b100);
    ext_trig = 1'b1;
    wait_wr("trig", 3, 4);
    check_writes("trig", 0, 256, 256, 1'b0, 1'b1);
    check_eq("trig_done_state", 32'({wr_en, busy, done, wr_addr}), 32'({3'b001, AW'(255)}));
    ext_trig = 1'b1;
    count_wr(10, c);
    ext_trig = 1'b0;
    count_wr(5, c2);
    check_eq("trig_ignored_after_done", 32'(c + c2), 32'd0);
    cntrl_bits = 8'h00;
    count_wr(8, c);
    check_eq("trig_release", 32'({done, busy}), 32'd0);

    // Continuous wrap; a depth_code change mid-run must not alter the latched depth.
    cntrl_bits = 8'h05;
    wait_wr("cont", 4, 5);
    check_writes("cont", 0, 20, 128, 1'b1, 1'b0);
    cntrl_bits = 8'h75;
    check_writes("cont", 20, 280, 128, 1'b1, 1'b0);
    cntrl_bits = 8'h00;
    wait_low("cont", 5);
    count_wr(4, c);
    check_eq("cont_idle", 32'({c[3:0], busy, done, wrapped}), 32'({4'd0, 3'b001}));

    // Abort during a deep capture; the re-written arm without a 0 in between is ignored.
    cntrl_bits = 8'h71;
    wait_wr("abort", 4, 5);
    check_writes("abort", 0, 1000, 16384, 1'b0, 1'b0);
    cntrl_bits = 8'hF1;
    wait_low("abort", 5);
    check_eq("abort_idle", 32'({busy, done}), 32'd0);
    cntrl_bits = 8'h71;
    count_wr(20, c);
    check_eq("abort_no_rearm", 32'({c[7:0], busy, done}), 32'd0);
    cntrl_bits = 8'h00;
    count_wr(8, c);
    cntrl_bits = 8'h71;
    wait_wr("rearm", 4, 5);
    check_writes("rearm", 0, 50, 16384, 1'b0, 1'b0);
    cntrl_bits = 8'h00;
    wait_low("rearm", 5);
    count_wr(6, c);

    // Skew filter: one-clock 0x81 on the way from 0x00 to 0x01.
    cntrl_bits = 8'h81;
    @(negedge clk);
    cntrl_bits = 8'h01;
    wait_wr("skew", 4, 5);
    check_writes("skew", 0, 128, 128, 1'b0, 1'b0);
    check_eq("skew_done", 32'({wr_en, busy, done}), 32'b001);
    cntrl_bits = 8'h00;
    count_wr(8, c);

    // Reset mid-capture clears outputs without waiting for a clock edge.
    cntrl_bits = 8'h01;
    wait_wr("rstmid", 4, 5);
    check_writes("rstmid", 0, 10, 128, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1 check_eq("rstmid_async_clear", 32'({wr_en, busy, done, wrapped, wr_addr, wr_data}), 32'd0);
    cntrl_bits = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    count_wr(6, c);
    check_eq("rstmid_after", 32'({c[3:0], busy, done}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Consumes the 8-bit control word written over SPI and runs one capture into the sample buffer RAM.
- The control word is produced in the SPI clock domain. This block brings it into the ADC sample clock domain and decodes it.
- Runs the arm/trigger/capture state machine.
- Drives write enable, address and data for the buffer memory. Reports busy/done status.

Parameters:
ADDR_W, 14, buffer address width; maximum depth is 2^ADDR_W samples
DATA_W, 12, sample width

Ports:
clk  input  1  ADC sample clock; the only clock of the block
rst_n  input  1  asynchronous, active-low reset
cntrl_bits  input  8  control word, asynchronous to clk (bit0 arm, bit1 trig_mode, bit2 continuous, bits6:4 depth_code, bit7 abort; bit3 reserved)
ext_trig  input  1  asynchronous external trigger, rising-edge active
data_in  input  DATA_W  ADC sample, valid every clk
wr_en  output  1  buffer write strobe
wr_addr  output  ADDR_W  buffer write address
wr_data  output  DATA_W  buffer write data
busy  output  1  high in ARMED or CAPTURE
done  output  1  high in DONE
wrapped  output  1  sticky: continuous capture has wrapped at least once

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are 0. State is IDLE. All sync/filter registers are 0.
- Sync: every cntrl_bits bit passes through 2 flops. ext_trig passes through 2 flops and then an edge-detect flop.
- Filter: the filtered control word updates only when the synchronized word is equal on 2 consecutive clks. This rejects multi-bit skew from the SPI write.
- Depth: depth = 2^(depth_code+7), clamped to 2^ADDR_W.
  - Default ADDR_W: code 0 is 128, code 7 is 16384.
  - depth_code is latched on the arm rising edge. Later changes are ignored until the next arm.
- Arm edge: detected on the filtered arm bit, rising from 0 to 1.
- IDLE:
  - On arm edge with abort=0: go to CAPTURE if trig_mode=0, else go to ARMED.
  - On entry: wr_addr cleared to 0 and wrapped cleared.
- ARMED:
  - Rising ext_trig edge: go to CAPTURE.
  - Filtered arm=0 or abort=1: go to IDLE.
- CAPTURE:
  - wr_en=1 every clk.
  - wr_data = data_in registered by 1 clk, aligned with wr_en/wr_addr.
  - wr_addr increments by 1 per clk, starting at 0.
- End of buffer (wr_addr = depth-1 with wr_en=1):
  - continuous=0: go to DONE.
  - continuous=1: next wr_addr is 0, set wrapped, stay in CAPTURE.
  - The continuous bit is read live, so clearing it mid-capture takes effect at the next end of buffer.
- Leaving CAPTURE: filtered arm=0 or abort=1 goes to IDLE. wr_en is 0 from the next clk. wr_addr keeps its last value until the next arm.
- DONE:
  - done=1, wr_en=0, wr_addr holds depth-1.
  - Filtered arm=0: go to IDLE.
  - arm held high never retriggers; a new capture needs arm 0 then 1.
- Abort priority: abort outranks arm in the same filtered word. An arm edge while abort=1 is ignored.
- Simultaneous events in ARMED: a trigger edge and arm=0 in the same clk go to IDLE.
- Latency: wr_en first goes high 4 clks after cntrl_bits arm is first sampled by sync stage 1 (trig_mode=0). The bench allows 4–5 clks for metastability.
- Trigger latency: ext_trig to first wr_en is 3–4 clks.
- Reset mid-capture: wr_en drops immediately (asynchronously) and done=0.

Test Plan:
- Reset: hold rst_n low, toggle cntrl_bits and ext_trig -> all outputs 0; after release with cntrl_bits=0, state IDLE and outputs stay 0.
- Immediate capture: write 0x01 (depth_code 0) -> after 4–5 clks, exactly 128 wr_en pulses, wr_addr 0..127, wr_data = data_in delayed 1 clk, then done=1 and busy=0; write 0x00 -> done=0.
- External trigger: write 0x13 (trig_mode, depth 256) -> busy=1 and no wr_en until an ext_trig rising edge; then 256 writes start within 3–4 clks; further ext_trig pulses ignored.
- Continuous wrap: write 0x05 -> wr_addr 0..127,0,1,…; wrapped=1 from the first wrap; write 0x00 -> wr_en low within 5 clks; state IDLE; done never set.
- Abort: write 0x71 (depth 16384), then after 1000 writes write 0xF1 -> wr_en low within 5 clks, IDLE; write 0x71 again -> no capture until arm goes 0 then 1.
- Skew filter: change cntrl_bits 0x00 -> 0x01 with a 1-clk intermediate glitch value 0x81 -> glitch rejected, capture starts normally.
